mem_bus_line_responder: RTL

- Responder end of the line-granular mem_bus protocol; L1 data caches and other line initiators connect to it.
- Accepts one whole-line load or store at a time from a single initiator.
- Holds line data in an internal line-organised array and answers after a fixed, programmable latency with a one-cycle mem_ready pulse.
- Serves as the L2/backing-memory stand-in for simulation and as the base for a future real L2.

---
 rtl/mem_bus_line_responder_if.sv | 23 ++
 rtl/mem_bus_line_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_bus_line_responder_if.sv
// Line-granular mem_bus: initiator request fields and responder completion fields.
// The master modport is the initiator side; the slave modport is the responder side.
interface mem_bus_line_responder_if #(
    parameter int CACHE_LINE_SIZE = 512,
    parameter int ADDR_WIDTH      = 32
);
    logic                       mem_req_load;
    logic                       mem_req_store;
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic [CACHE_LINE_SIZE-1:0] mem_data_out;
    logic                       mem_ready;
    logic [CACHE_LINE_SIZE-1:0] mem_data;

    modport master (
        output mem_req_load, mem_req_store, mem_addr, mem_data_out,
        input  mem_ready, mem_data
    );

    modport slave (
        input  mem_req_load, mem_req_store, mem_addr, mem_data_out,
        output mem_ready, mem_data
    );
endinterface

// File: rtl/mem_bus_line_responder.sv
// Whole-line mem_bus responder with fixed-latency single-cycle completion pulse.
// Optional MEM_BUS_RESPONDER_STATS_EN adds load/store/busy-cycle counters.
module mem_bus_line_responder #(
    parameter int CACHE_LINE_SIZE = 512,
    parameter int DEPTH           = 1024,
    parameter int LATENCY         = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    mem_bus_line_responder_if.slave  bus,
    output logic                     proto_err
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int ADDR_W = $bits(bus.mem_addr);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

    state_t                     state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic                       op_store_reg;
    logic [IDX_W-1:0]           idx_reg;
    logic [CACHE_LINE_SIZE-1:0] line_reg;
    logic [CACHE_LINE_SIZE-1:0] mem_data_reg;
    logic                       proto_err_reg;

    logic [CACHE_LINE_SIZE-1:0] line_mem [DEPTH];

    logic                       req_any;
    logic                       accept;
    logic                       enter_resp;
    logic                       cur_store;
    logic [IDX_W-1:0]           cur_idx;
    logic [CACHE_LINE_SIZE-1:0] cur_line;
    logic                       unused_addr_bits;

    assign req_any = bus.mem_req_load | bus.mem_req_store;
    assign accept  = (state_reg == IDLE) && req_any;
    assign unused_addr_bits = ^bus.mem_addr[ADDR_W-1:IDX_W];

    // With LATENCY==1 the response is entered straight from IDLE, so the live
    // request fields stand in for the not-yet-latched ones.
    assign cur_store = (state_reg == IDLE) ? bus.mem_req_store : op_store_reg;
    assign cur_idx   = (state_reg == IDLE) ? bus.mem_addr[IDX_W-1:0] : idx_reg;
    assign cur_line  = (state_reg == IDLE) ? bus.mem_data_out : line_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = DRAIN;
            DRAIN:   if (!req_any) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state_reg != RESP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            op_store_reg  <= 1'b0;
            idx_reg       <= '0;
            line_reg      <= '0;
            mem_data_reg  <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                op_store_reg <= bus.mem_req_store;
                idx_reg      <= bus.mem_addr[IDX_W-1:0];
                line_reg     <= bus.mem_data_out;
                if (bus.mem_req_load && bus.mem_req_store) begin
                    proto_err_reg <= 1'b1;
                end
            end
            if (enter_resp) begin
                mem_data_reg <= cur_store ? cur_line : line_mem[cur_idx];
            end
        end
    end

    // Array is never reset; the write is gated by reset so a pending store is dropped.
    always_ff @(posedge clock) begin
        if (enter_resp && cur_store && !reset) begin
            line_mem[cur_idx] <= cur_line;
        end
    end

    assign bus.mem_ready = (state_reg == RESP);
    assign bus.mem_data  = mem_data_reg;
    assign proto_err     = proto_err_reg;

`ifdef MEM_BUS_RESPONDER_STATS_EN
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;
    logic [31:0] busy_cycles;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_cnt    <= '0;
            store_cnt   <= '0;
            busy_cycles <= '0;
        end else begin
            if (state_reg == RESP && !op_store_reg && load_cnt != '1) begin
                load_cnt <= load_cnt + 32'd1;
            end
            if (state_reg == RESP && op_store_reg && store_cnt != '1) begin
                store_cnt <= store_cnt + 32'd1;
            end
            if (state_reg != IDLE && busy_cycles != '1) begin
                busy_cycles <= busy_cycles + 32'd1;
            end
        end
    end
`endif
endmodule
